ssd_scanner: RTL and testbench



---
 rtl/ssd_scanner_if.sv | 30 +++
 rtl/ssd_scanner.sv | 104 ++++++++++
 tb/tb_ssd_scanner.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ssd_scanner_if: digit nibble inputs and pin-side outputs of the      |
// | seven-segment scanner.  Rev 1.0                                      |
// +----------------------------------------------------------------------+
interface ssd_scanner_if;
   logic       digit0_en_i;
   logic       digit1_en_i;
   logic       digit2_en_i;
   logic       digit3_en_i;
   logic [3:0] digit0_i;
   logic [3:0] digit1_i;
   logic [3:0] digit2_i;
   logic [3:0] digit3_i;
   logic [3:0] anode_o;
   logic [6:0] segments_o;

   modport master (
      output digit0_en_i, digit1_en_i, digit2_en_i, digit3_en_i,
      output digit0_i, digit1_i, digit2_i, digit3_i,
      input  anode_o, segments_o
   );

   modport slave (
      input  digit0_en_i, digit1_en_i, digit2_en_i, digit3_en_i,
      input  digit0_i, digit1_i, digit2_i, digit3_i,
      output anode_o, segments_o
   );
endinterface
`default_nettype wire

// File: rtl/ssd_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ssd_scanner: 4-digit common-anode 7-segment scan driver with hex     |
// | decode. Optional anode blanking via macro SSD_SCANNER_BLANK_EN.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ssd_scanner #(
   parameter int unsigned CLK_DIV      = 1024,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   ssd_scanner_if.slave bus
);
   localparam int unsigned        C_CNT_W   = $clog2(CLK_DIV);
   localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(CLK_DIV - 1);

   if ((CLK_DIV < 2) || (CLK_DIV > (1 << 20))) begin : g_bad_clk_div
      $error("ssd_scanner: CLK_DIV out of range");
   end
   if (BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
      $error("ssd_scanner: BLANK_CYCLES must be below CLK_DIV");
   end

   logic [1:0]         idx_q, idx_d;
   logic [C_CNT_W-1:0] cnt_q, cnt_d;
   logic               en_q,  en_d;
   logic [6:0]         seg_q, seg_d;

   logic               w_wrap;
   logic               w_blank;
   logic [3:0]         w_en_vec;
   logic [3:0]         w_val [4];

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0:    return 7'h40;
         4'h1:    return 7'h79;
         4'h2:    return 7'h24;
         4'h3:    return 7'h30;
         4'h4:    return 7'h19;
         4'h5:    return 7'h12;
         4'h6:    return 7'h02;
         4'h7:    return 7'h78;
         4'h8:    return 7'h00;
         4'h9:    return 7'h10;
         4'hA:    return 7'h08;
         4'hB:    return 7'h03;
         4'hC:    return 7'h46;
         4'hD:    return 7'h21;
         4'hE:    return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   assign w_en_vec = {bus.digit3_en_i, bus.digit2_en_i, bus.digit1_en_i, bus.digit0_en_i};
   assign w_val[0] = bus.digit0_i;
   assign w_val[1] = bus.digit1_i;
   assign w_val[2] = bus.digit2_i;
   assign w_val[3] = bus.digit3_i;

   // Digit inputs are only looked at on the wrap edge, for the digit about to be shown.
   always_comb begin
      w_wrap = (cnt_q == C_CNT_MAX);
      cnt_d  = w_wrap ? '0 : cnt_q + C_CNT_W'(1);
      idx_d  = idx_q;
      en_d   = en_q;
      seg_d  = seg_q;
      if (w_wrap) begin
         idx_d = idx_q + 2'd1;
         en_d  = w_en_vec[idx_d];
         seg_d = hex_to_seg(w_val[idx_d]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= 2'd3;
         cnt_q <= C_CNT_MAX;
         en_q  <= 1'b0;
         seg_q <= 7'h7F;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         en_q  <= en_d;
         seg_q <= seg_d;
      end
   end

`ifdef SSD_SCANNER_BLANK_EN
   localparam logic [C_CNT_W-1:0] C_BLANK = C_CNT_W'(BLANK_CYCLES);
   assign w_blank = (cnt_q < C_BLANK);
`else
   assign w_blank = 1'b0;
`endif

   assign bus.anode_o    = (en_q && !w_blank) ? ~(4'b0001 << idx_q) : 4'hF;
   assign bus.segments_o = en_q ? seg_q : 7'h7F;

   a_one_anode : assert property (@(posedge clk_i) $countones(~bus.anode_o) <= 1)
      else $error("ssd_scanner: more than one anode active");

endmodule
`default_nettype wire

// File: tb/tb_ssd_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ssd_scanner: self-checking bench for ssd_scanner (CLK_DIV=8,      |
// | BLANK_CYCLES=2), slot/snapshot reference model.  Rev 1.0             |
// +----------------------------------------------------------------------+
module tb_ssd_scanner;
   localparam int CLK_DIV = 8;
   localparam int BLANK   = 2;
`ifdef SSD_SCANNER_BLANK_EN
   localparam int BLANK_EFF = BLANK;
`else
   localparam int BLANK_EFF = 0;
`endif

   typedef struct {
      logic [3:0] val;
      logic [6:0] seg;
   } dec_vec_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en  [4];
   logic [3:0] val [4];
   logic [6:0] seg_ref [16];
   dec_vec_t   dec_tab [16];

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state: edges since reset release, and the latched slot contents.
   int         edges;
   int         m_slot;
   int         m_pos;
   logic       m_en;
   logic [3:0] m_val;

   ssd_scanner_if u_if ();
   assign u_if.digit0_en_i = en[0];
   assign u_if.digit1_en_i = en[1];
   assign u_if.digit2_en_i = en[2];
   assign u_if.digit3_en_i = en[3];
   assign u_if.digit0_i    = val[0];
   assign u_if.digit1_i    = val[1];
   assign u_if.digit2_i    = val[2];
   assign u_if.digit3_i    = val[3];

   ssd_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (u_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      edges  = 0;
      m_en   = 1'b0;
      m_val  = 4'h0;
      m_slot = 0;
      m_pos  = 0;
   endtask

   task automatic model_edge();
      edges++;
      m_pos  = (edges - 1) % CLK_DIV;
      m_slot = ((edges - 1) / CLK_DIV) % 4;
      if (m_pos == 0) begin
         m_en  = en[m_slot];
         m_val = val[m_slot];
      end
   endtask

   function automatic logic [3:0] exp_anode();
      if (edges == 0 || !m_en || m_pos < BLANK_EFF) return 4'hF;
      return ~(4'b0001 << m_slot);
   endfunction

   function automatic logic [6:0] exp_seg();
      if (edges == 0 || !m_en) return 7'h7F;
      return seg_ref[m_val];
   endfunction

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check({tag, "_anode"}, 16'(u_if.anode_o), 16'(exp_anode()));
      check({tag, "_seg"}, 16'(u_if.segments_o), 16'(exp_seg()));
      n_total++;
      if ($countones(~u_if.anode_o) <= 1) n_pass++;
      else $display("FAIL %s_onehot: anode %0h has several bits low", tag, u_if.anode_o);
   endtask

   task automatic do_reset(input int ncyc);
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         check("reset_anode", 16'(u_if.anode_o), 16'h000F);
         check("reset_seg", 16'(u_if.segments_o), 16'h007F);
      end
      rst_n = 1'b1;
   endtask

   task automatic set_digits(input logic [3:0] e, input logic [3:0] v0, input logic [3:0] v1,
                             input logic [3:0] v2, input logic [3:0] v3);
      for (int i = 0; i < 4; i++) en[i] = e[i];
      val[0] = v0; val[1] = v1; val[2] = v2; val[3] = v3;
   endtask

   initial begin
      seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      for (int i = 0; i < 16; i++) dec_tab[i] = '{4'(i), seg_ref[i]};
      set_digits(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4);
      model_reset();

      // Reset hold, then a full scan plus part of the next with digits 1,2,3,4.
      do_reset(3);
      for (int i = 0; i < 40; i++) begin
         cycle("scan");
         if (i == 0)  check("first_slot_seg", 16'(u_if.segments_o), 16'h0079);
         if (i == 2)  check("slot0_anode", 16'(u_if.anode_o), 16'h000E);
         if (i == 9)  check("slot1_seg", 16'(u_if.segments_o), 16'h0024);
         if (i == 31) check("slot3_anode", 16'(u_if.anode_o), 16'h0007);
         if (i == 32) check("rescan_seg", 16'(u_if.segments_o), 16'h0079);
      end

      // Hex decode table, one reset + first slot per entry.
      for (int k = 0; k < 16; k++) begin
         set_digits(4'b0001, dec_tab[k].val, 4'h0, 4'h0, 4'h0);
         do_reset(1);
         cycle("dec");
         check("dec_tab_seg", 16'(u_if.segments_o), 16'(dec_tab[k].seg));
         check("dec_tab_anode", 16'(u_if.anode_o), (BLANK_EFF > 0) ? 16'h000F : 16'h000E);
      end

      // Disabled digit 2 keeps its slot.
      set_digits(4'b1011, 4'hF, 4'h8, 4'hA, 4'h0);
      do_reset(2);
      for (int i = 0; i < 40; i++) begin
         cycle("dis");
         if (i == 0)  check("dis_slot0_seg", 16'(u_if.segments_o), 16'h000E);
         if (i == 8)  check("dis_slot1_seg", 16'(u_if.segments_o), 16'h0000);
         if (i == 20) check("dis_slot2_anode", 16'(u_if.anode_o), 16'h000F);
         if (i == 20) check("dis_slot2_seg", 16'(u_if.segments_o), 16'h007F);
         if (i == 24) check("dis_slot3_seg", 16'(u_if.segments_o), 16'h0040);
         if (i == 32) check("dis_period_seg", 16'(u_if.segments_o), 16'h000E);
      end

      // Mid-slot change on digit 1 is deferred to the next scan.
      set_digits(4'b1111, 4'h0, 4'h5, 4'h0, 4'h0);
      do_reset(2);
      for (int i = 0; i < 48; i++) begin
         cycle("mid");
         if (i == 10) val[1] = 4'h6;
         if (i == 15) check("mid_hold_seg", 16'(u_if.segments_o), 16'h0012);
         if (i == 40) check("mid_next_seg", 16'(u_if.segments_o), 16'h0002);
      end

      // Asynchronous reset inside slot 2.
      set_digits(4'b1111, 4'h3, 4'h7, 4'h9, 4'hC);
      do_reset(1);
      for (int i = 0; i < 20; i++) cycle("pre_async");
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_anode", 16'(u_if.anode_o), 16'h000F);
      check("async_seg", 16'(u_if.segments_o), 16'h007F);
      @(posedge clk);
      #1;
      check("async_hold_seg", 16'(u_if.segments_o), 16'h007F);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle("post_async");
         if (i == 4) check("restart_anode", 16'(u_if.anode_o), 16'h000E);
         if (i == 4) check("restart_seg", 16'(u_if.segments_o), 16'h0030);
      end

      // Randomised digit traffic against the model.
      do_reset(1);
      for (int i = 0; i < 600; i++) begin
         cycle("rand");
         if ($urandom_range(3, 0) == 0) begin
            int d;
            d      = $urandom_range(3, 0);
            en[d]  = ($urandom_range(4, 0) != 0);
            val[d] = 4'($urandom_range(15, 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
